// File: rtl/logistic_seq_mc_if.sv
// Seed/output handshake bundle for the multi-channel logistic chaos generator.
// Channel k of chaos_x0 / chaos_xout sits at bits [k*W +: W].
interface logistic_seq_mc_if #(
  parameter int CH = 2,
  parameter int W  = 16
);
  logic [CH*W-1:0] chaos_x0;
  logic [W+1:0]    chaos_mu;
  logic            chaos_x0_vld;
  logic            chaos_x0_rdy;
  logic            chaos_stop;
  logic [CH*W-1:0] chaos_xout;
  logic            chaos_xout_vld;
  logic            chaos_xout_rdy;
  logic            chaos_busy;

  modport master (
    output chaos_x0, chaos_mu, chaos_x0_vld, chaos_stop, chaos_xout_rdy,
    input  chaos_x0_rdy, chaos_xout, chaos_xout_vld, chaos_busy
  );

  modport slave (
    input  chaos_x0, chaos_mu, chaos_x0_vld, chaos_stop, chaos_xout_rdy,
    output chaos_x0_rdy, chaos_xout, chaos_xout_vld, chaos_busy
  );
endinterface

// File: rtl/logistic_seq_mc.sv
// CH-channel logistic map x <- mu*x*(1-x) in Q0.W with shared mu, burn-in and handshakes.
// One lane instance per channel; the FSM only sequences the two-phase update.
module logistic_seq_mc_lane #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_i,
  input  logic           calc_a_i,
  input  logic           calc_b_i,
  input  logic [W-1:0]   seed_i,
  input  logic [W+1:0]   mu_i,
  output logic [W-1:0]   x_nxt_o
);
  localparam logic [2*W-1:0] ONE = (2*W)'(1) << W;

  logic [W-1:0]     x_q, t_q, t_d, y, seed_fix;
  logic [2*W-1:0]   sq;
  logic [2*W+1:0]   my;
  logic [W+1:0]     y_full;

  always_comb begin
    sq       = (2*W)'(x_q) * (ONE - (2*W)'(x_q));
    t_d      = W'(sq >> W);
    my       = (2*W+2)'(mu_i) * (2*W+2)'(t_q);
    y_full   = (W+2)'(my >> W);
    // Saturate above 1.0 and never let a lane collapse onto the zero fixed point.
    if (|y_full[W+1:W])       y = '1;
    else if (y_full == '0)    y = W'(1);
    else                      y = y_full[W-1:0];
    seed_fix = (seed_i == '0) ? W'(1) : seed_i;
    x_nxt_o  = ld_i ? seed_fix : (calc_b_i ? y : x_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      t_q <= '0;
    end else begin
      if (ld_i || calc_b_i) x_q <= x_nxt_o;
      if (calc_a_i)         t_q <= t_d;
    end
  end
endmodule

module logistic_seq_mc #(
  parameter int CH         = 2,
  parameter int W          = 16,
  parameter int ITERATIONS = 200,
  parameter int MODE       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  logistic_seq_mc_if.slave   bus
);
  localparam int CW = (ITERATIONS < 1) ? 1 : $clog2(ITERATIONS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS);

  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, OUT} state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [W+1:0]           mu_q;
  logic                   stream_q;
  logic                   vld_q;
  logic [CH-1:0][W-1:0]   xout_q;
  logic [CH-1:0][W-1:0]   seed;
  logic [CH-1:0][W-1:0]   x_nxt;
  logic                   rdy, accept, calc_a, calc_b;

  assign seed   = bus.chaos_x0;
  // Stop gates ready so a seed offered alongside stop is never taken.
  assign rdy    = (state_q == IDLE) && !bus.chaos_stop;
  assign accept = rdy && bus.chaos_x0_vld;
  assign calc_a = (state_q == CALC_A);
  assign calc_b = (state_q == CALC_B);
  assign cnt_d  = cnt_q + 1'b1;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logistic_seq_mc_lane #(.W(W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_i     (accept),
      .calc_a_i (calc_a),
      .calc_b_i (calc_b),
      .seed_i   (seed[k]),
      .mu_i     (mu_q),
      .x_nxt_o  (x_nxt[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mu_q     <= '0;
      stream_q <= 1'b0;
      vld_q    <= 1'b0;
      xout_q   <= '0;
    end else if (bus.chaos_stop) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mu_q     <= bus.chaos_mu;
          cnt_q    <= '0;
          stream_q <= 1'b0;
          if (ITERATIONS == 0) begin
            state_q <= OUT;
            vld_q   <= 1'b1;
            xout_q  <= x_nxt;
          end else begin
            state_q <= CALC_A;
          end
        end
        CALC_A: state_q <= CALC_B;
        CALC_B: begin
          // Once streaming, every further iteration is a beat; burn-in count no longer applies.
          if (MODE == 1 && stream_q) begin
            state_q <= OUT;
            vld_q   <= 1'b1;
            xout_q  <= x_nxt;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == LAST) begin
              state_q <= OUT;
              vld_q   <= 1'b1;
              xout_q  <= x_nxt;
            end else begin
              state_q <= CALC_A;
            end
          end
        end
        OUT: if (bus.chaos_xout_rdy) begin
          vld_q    <= 1'b0;
          stream_q <= 1'b1;
          state_q  <= (MODE == 1) ? CALC_A : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.chaos_x0_rdy   = rdy;
  assign bus.chaos_xout     = xout_q;
  assign bus.chaos_xout_vld = vld_q;
  assign bus.chaos_busy     = (state_q != IDLE);
endmodule

// File: tb/tb_logistic_seq_mc.sv
// Directed + randomized bench for logistic_seq_mc across four parameter sets,
// compared against an arithmetic model of the logistic iteration.
module tb_logistic_seq_mc;
  localparam int ITS [4] = '{1, 2, 0, 200};
  localparam int MDS [4] = '{0, 0, 1, 0};

  logic clk, rst_n;
  logic [31:0] x0 [4];
  logic [17:0] mu [4];
  logic        x0_vld [4];
  logic        stop [4];
  logic        ordy [4];
  wire  [31:0] xout [4];
  wire         vld [4];
  wire         irdy [4];
  wire         busy [4];

  int checks = 0;
  int errs   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logistic_seq_mc_if #(.CH(2), .W(16)) bus ();
    assign bus.chaos_x0       = x0[g];
    assign bus.chaos_mu       = mu[g];
    assign bus.chaos_x0_vld   = x0_vld[g];
    assign bus.chaos_stop     = stop[g];
    assign bus.chaos_xout_rdy = ordy[g];
    assign xout[g] = bus.chaos_xout;
    assign vld[g]  = bus.chaos_xout_vld;
    assign irdy[g] = bus.chaos_x0_rdy;
    assign busy[g] = bus.chaos_busy;
    logistic_seq_mc #(.CH(2), .W(16), .ITERATIONS(ITS[g]), .MODE(MDS[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint mstep(input longint x, input longint m);
    longint t, y;
    t = (x * (65536 - x)) / 65536;
    y = (m * t) / 65536;
    if (y > 65535) y = 65535;
    if (y == 0) y = 1;
    return y;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] s, input logic [17:0] m, input int n);
    logic [31:0] r;
    longint x;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      x = longint'(s[k*16 +: 16]);
      if (x == 0) x = 1;
      for (int i = 0; i < n; i++) x = mstep(x, longint'(m));
      r[k*16 +: 16] = x[15:0];
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where vld is first seen.
  task automatic run_seed(input int d, input logic [31:0] s, input logic [17:0] m,
                          output int lat, output logic [31:0] dat);
    x0[d] = s; mu[d] = m; x0_vld[d] = 1'b1;
    #1;
    chk("seed_rdy", 64'(irdy[d]), 64'd1);
    @(negedge clk);
    x0_vld[d] = 1'b0;
    lat = 1;
    while (!vld[d] && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    dat = xout[d];
  endtask

  initial begin
    int lat, gap, stable;
    logic [31:0] dat, s, exp0;
    logic [17:0] m;

    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      x0[d] = '0; mu[d] = '0; x0_vld[d] = 1'b0; stop[d] = 1'b0; ordy[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst_vld",  64'(vld[d]),  64'd0);
      chk("rst_busy", 64'(busy[d]), 64'd0);
      chk("rst_xout", 64'(xout[d]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) chk("rst_rdy", 64'(irdy[d]), 64'd1);

    // Directed vectors on ITERATIONS=1 and ITERATIONS=2.
    run_seed(0, 32'h4000_8000, 18'h3FFFF, lat, dat);
    chk("it1_lat", 64'(lat), 64'd3);
    chk("it1_dat", 64'(dat), 64'hBFFF_FFFF);
    @(negedge clk);
    chk("it1_vld_drop", 64'(vld[0]), 64'd0);
    chk("it1_idle_rdy", 64'(irdy[0]), 64'd1);
    chk("it1_idle_busy", 64'(busy[0]), 64'd0);

    run_seed(0, 32'h0000_4000, 18'h20000, lat, dat);
    chk("mu2_dat", 64'(dat), 64'h0001_6000);
    @(negedge clk);

    run_seed(1, 32'h8000_8000, 18'h3FFFF, lat, dat);
    chk("it2_lat", 64'(lat), 64'd5);
    chk("it2_dat", 64'(dat), 64'h0001_0001);
    @(negedge clk);

    // Randomized seeds and gains against the model.
    for (int r = 0; r < 12; r++) begin
      int d;
      d = r % 2;
      s = $urandom;
      if (r == 4) s[15:0] = 16'h0;
      m = 18'($urandom_range(0, 18'h3FFFF));
      run_seed(d, s, m, lat, dat);
      chk("rnd_lat", 64'(lat), 64'(2 * ITS[d] + 1));
      chk("rnd_dat", 64'(dat), 64'(model(s, m, ITS[d])));
      @(negedge clk);
      chk("rnd_idle", 64'(busy[d]), 64'd0);
    end

    // Continuous mode, ITERATIONS=0: beats every 3 cycles, then backpressure.
    s = {16'($urandom_range(1, 16'hFFFF)), 16'h4000};
    run_seed(2, s, 18'h20000, lat, dat);
    chk("str_lat", 64'(lat), 64'd1);
    chk("str_b0", 64'(dat[15:0]), 64'h4000);
    chk("str_b0_all", 64'(dat), 64'(model(s, 18'h20000, 0)));
    for (int b = 1; b < 3; b++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!vld[2] && gap < 100);
      chk("str_gap", 64'(gap), 64'd3);
      chk("str_beat", 64'(xout[2]), 64'(model(s, 18'h20000, b)));
    end
    chk("str_b2_ch0", 64'(xout[2][15:0]), 64'h7800);
    ordy[2] = 1'b0;
    exp0 = model(s, 18'h20000, 2);
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vld[2] && xout[2] == exp0) stable++;
    end
    chk("bp_stable", 64'(stable), 64'd10);
    stop[2] = 1'b1;
    @(negedge clk);
    stop[2] = 1'b0;
    #1;
    chk("stop_out_vld", 64'(vld[2]), 64'd0);
    chk("stop_out_busy", 64'(busy[2]), 64'd0);
    chk("stop_out_rdy", 64'(irdy[2]), 64'd1);
    ordy[2] = 1'b1;
    @(negedge clk);

    // Stop in CALC_B (cycle 2 after acceptance on ITERATIONS=2).
    x0[1] = 32'h1234_5678; mu[1] = 18'h3FFFF; x0_vld[1] = 1'b1;
    @(negedge clk);
    x0_vld[1] = 1'b0;
    @(negedge clk);
    stop[1] = 1'b1;
    @(negedge clk);
    stop[1] = 1'b0;
    #1;
    chk("stop_cb_busy", 64'(busy[1]), 64'd0);
    chk("stop_cb_vld", 64'(vld[1]), 64'd0);
    chk("stop_cb_rdy", 64'(irdy[1]), 64'd1);
    @(negedge clk);
    s = $urandom; m = 18'($urandom_range(0, 18'h3FFFF));
    run_seed(1, s, m, lat, dat);
    chk("post_stop_lat", 64'(lat), 64'd5);
    chk("post_stop_dat", 64'(dat), 64'(model(s, m, 2)));
    @(negedge clk);

    // Stop together with a seed in IDLE: seed must be ignored.
    x0[0] = 32'hAAAA_5555; mu[0] = 18'h3FFFF; x0_vld[0] = 1'b1; stop[0] = 1'b1;
    #1;
    chk("stop_idle_rdy", 64'(irdy[0]), 64'd0);
    @(negedge clk);
    x0_vld[0] = 1'b0; stop[0] = 1'b0;
    chk("stop_idle_busy", 64'(busy[0]), 64'd0);
    repeat (3) @(negedge clk);
    chk("stop_idle_novld", 64'(vld[0]), 64'd0);

    // Asynchronous reset mid burn-in, then full 200-iteration run.
    x0[3] = 32'h3333_7777; mu[3] = 18'h3FFFF; x0_vld[3] = 1'b1;
    @(negedge clk);
    x0_vld[3] = 1'b0;
    repeat (100) @(negedge clk);
    chk("burn_busy", 64'(busy[3]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy[3]), 64'd0);
    chk("arst_vld", 64'(vld[3]), 64'd0);
    chk("arst_rdy", 64'(irdy[3]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = $urandom; m = 18'($urandom_range(18'h30000, 18'h3FFFF));
    run_seed(3, s, m, lat, dat);
    chk("it200_lat", 64'(lat), 64'd401);
    chk("it200_dat", 64'(dat), 64'(model(s, m, 200)));
    @(negedge clk);
    chk("it200_idle", 64'(busy[3]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule
